// File: rtl/lns_accum_sequencer.sv
// ---------------------------------------------------------------------------
// lns_accum_sequencer
//
// Reduces a stream of signed LNS operands (two's-complement log magnitude plus
// sign bit) to one LNS sum. It uses a single external combinational LNS adder
// (logAddition_nonUniform). This block drives the adder's X/Y/Sx/Sy inputs.
// It also holds the running accumulator and sequences the operand and result
// handshakes.
//
// Flow:
//   - start with len == 0 goes straight to DONE with an exact-zero result.
//   - Otherwise the first operand is loaded into the accumulator as-is.
//   - Each later operand is added to the accumulator through the adder.
//
// Optional build macro:
//   LNS_ACC_REG_EN
//     Registers the adder result before it reaches the accumulator. This cuts
//     the long combinational path through the adder. Each ACCUM handshake is
//     followed by one WAIT cycle (in_ready low), so accumulation runs at one
//     operand per two cycles. FIRST is unaffected.
//   Undefined (default)
//     No pipe register. Throughput is one operand per cycle.
//
// FRAC only documents the fixed-point position of the log magnitude. The
// sequencer never interprets the value.
// ---------------------------------------------------------------------------
module lns_accum_sequencer #(
  parameter int BIT_SIZE = 18,
  parameter int FRAC     = 9,
  parameter int LEN_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  // reduction control
  input  logic                start,
  input  logic [LEN_W-1:0]    len,
  // operand stream
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BIT_SIZE-1:0] in_x,
  input  logic                in_sx,
  // external LNS adder
  output logic [BIT_SIZE-1:0] add_x,
  output logic                add_sx,
  output logic [BIT_SIZE-1:0] add_y,
  output logic                add_sy,
  input  logic [BIT_SIZE-1:0] add_z,
  input  logic                add_sz,
  // result stream
  output logic                out_valid,
  input  logic                out_ready,
  output logic [BIT_SIZE-1:0] out_z,
  output logic                out_sz,
  output logic                out_zero,
  output logic                busy
);

  // A fractional field as wide as the word leaves no integer bit for the log.
  if (FRAC < 0 || FRAC >= BIT_SIZE) begin : g_frac_check
    $error("lns_accum_sequencer: FRAC must lie in [0, BIT_SIZE-1]");
  end

`ifdef LNS_ACC_REG_EN
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FIRST = 3'd1,
    S_ACCUM = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FIRST = 3'd1,
    S_ACCUM = 3'd2,
    S_DONE  = 3'd4
  } state_e;
`endif

  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

  state_e              state_q;
  logic [BIT_SIZE-1:0] acc_q;        // running log magnitude
  logic                acc_s_q;      // running sign
  logic [LEN_W-1:0]    cnt_q;        // operands still to accept
  logic                in_ready_q;
  logic                out_valid_q;
  logic [BIT_SIZE-1:0] out_z_q;
  logic                out_sz_q;
  logic                out_zero_q;
  logic                busy_q;
`ifdef LNS_ACC_REG_EN
  logic [BIT_SIZE-1:0] pipe_z_q;     // registered adder result
  logic                pipe_s_q;
`endif

  logic in_hs;
  logic out_hs;

  // in_ready_q is only ever high in FIRST/ACCUM, so in_valid elsewhere is ignored.
  assign in_hs  = in_valid & in_ready_q;
  assign out_hs = out_valid_q & out_ready;

  // Adder operands: accumulator on X, incoming operand on Y, no registering.
  assign add_x  = acc_q;
  assign add_sx = acc_s_q;
  assign add_y  = in_x;
  assign add_sy = in_sx;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_z     = out_z_q;
  assign out_sz    = out_sz_q;
  assign out_zero  = out_zero_q;
  assign busy      = busy_q;

  // Sequencer FSM. Every output is registered and set together with the state
  // it belongs to. The outputs therefore never glitch and change exactly on
  // state entry.
  // NOTE: every assignment here is non-blocking. Each register samples
  // pre-edge values, so the order of statements within a branch cannot
  // change the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      acc_s_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_z_q     <= '0;
      out_sz_q    <= 1'b0;
      out_zero_q  <= 1'b0;
      busy_q      <= 1'b0;
`ifdef LNS_ACC_REG_EN
      pipe_z_q    <= '0;
      pipe_s_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        // Wait for start. len is only looked at together with start.
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (len == '0) begin
              // Empty reduction: exact zero, no operands requested.
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              out_zero_q  <= 1'b1;
              out_z_q     <= '0;
              out_sz_q    <= 1'b0;
            end else begin
              state_q    <= S_FIRST;
              cnt_q      <= len;
              in_ready_q <= 1'b1;
            end
          end
        end

        // The first operand seeds the accumulator directly. Adding it to a
        // zero accumulator is avoided because LNS has no exact zero.
        S_FIRST: begin
          if (in_hs) begin
            acc_q   <= in_x;
            acc_s_q <= in_sx;
            cnt_q   <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              state_q     <= S_DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_z_q     <= in_x;
              out_sz_q    <= in_sx;
            end else begin
              state_q <= S_ACCUM;
            end
          end
        end

        // Fold each accepted operand into the accumulator through the adder.
        // The count only moves on a handshake and the state exits at 1, so
        // the counter never wraps even for the largest len.
        S_ACCUM: begin
          if (in_hs) begin
            cnt_q <= cnt_q - CNT_ONE;
`ifdef LNS_ACC_REG_EN
            pipe_z_q   <= add_z;
            pipe_s_q   <= add_sz;
            in_ready_q <= 1'b0;
            state_q    <= S_WAIT;
`else
            acc_q   <= add_z;
            acc_s_q <= add_sz;
            if (cnt_q == CNT_ONE) begin
              state_q     <= S_DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_z_q     <= add_z;
              out_sz_q    <= add_sz;
            end
`endif
          end
        end

`ifdef LNS_ACC_REG_EN
        // Move the registered sum into the accumulator. cnt_q was already
        // decremented on the handshake, so zero here means that was the last
        // operand.
        S_WAIT: begin
          acc_q   <= pipe_z_q;
          acc_s_q <= pipe_s_q;
          if (cnt_q == '0) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            out_z_q     <= pipe_z_q;
            out_sz_q    <= pipe_s_q;
          end else begin
            state_q    <= S_ACCUM;
            in_ready_q <= 1'b1;
          end
        end
`endif

        // Hold the result until the consumer takes it, then go idle.
        S_DONE: begin
          if (out_hs) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_zero_q  <= 1'b0;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          out_zero_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lns_accum_sequencer.sv
// ---------------------------------------------------------------------------
// Testbench for lns_accum_sequencer.
//
// The add_* ports are closed by a behavioural LNS adder. It computes the
// result with real arithmetic:
//   z = max(x, y) + round(512 * log2(1 +/- 2^(-|x-y|/512)))
// That is the ideal response of logAddition_nonUniform at FRAC = 9.
//
// Every expected sum below was worked out by hand for operands whose results
// are easy to derive.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lns_accum_sequencer;

  localparam int BW = 18;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] len_v;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_x;
  logic          in_sx;
  logic [BW-1:0] add_x, add_y, add_z;
  logic          add_sx, add_sy, add_sz;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_z;
  logic          out_sz;
  logic          out_zero;
  logic          busy;

  int vec_count = 0;
  int err_count = 0;

  always #5 clk = ~clk;

  lns_accum_sequencer #(.BIT_SIZE(BW), .FRAC(9), .LEN_W(LW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .len      (len_v),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_sx    (in_sx),
    .add_x    (add_x),
    .add_sx   (add_sx),
    .add_y    (add_y),
    .add_sy   (add_sy),
    .add_z    (add_z),
    .add_sz   (add_sz),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_z    (out_z),
    .out_sz   (out_sz),
    .out_zero (out_zero),
    .busy     (busy)
  );

  // Ideal LNS adder, result packed as {sign, log magnitude}.
  function automatic logic [BW:0] lns_add(input logic [BW-1:0] x, input logic sx,
                                          input logic [BW-1:0] y, input logic sy);
    int  xi, yi, big, corr;
    logic sbig;
    real d, f;
    xi = int'($signed(x));
    yi = int'($signed(y));
    if (xi >= yi) begin big = xi; sbig = sx; d = real'(xi - yi); end
    else          begin big = yi; sbig = sy; d = real'(yi - xi); end
    if (sx == sy) f = 1.0 + $pow(2.0, -d / 512.0);
    else          f = 1.0 - $pow(2.0, -d / 512.0);
    if (f <= 0.0) return {1'b0, 1'b1, {(BW-1){1'b0}}};  // exact cancellation
    corr = $rtoi($floor(512.0 * $ln(f) / $ln(2.0) + 0.5));
    return {sbig, BW'(big + corr)};
  endfunction

  always_comb {add_sz, add_z} = lns_add(add_x, add_sx, add_y, add_sy);

  // Watchdog: no test may stall the run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---- stimulus helpers (called at a falling edge, return at a falling edge)
  task automatic do_start(input logic [LW-1:0] n);
    start = 1'b1; len_v = n;
    @(negedge clk);
    start = 1'b0; len_v = '0;
  endtask

  task automatic send_op(input logic [BW-1:0] x, input logic sx);
    int n = 0;
    in_valid = 1'b1; in_x = x; in_sx = sx;
    while (in_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin
      vec_count++; err_count++;
      $display("FAIL send_op_timeout: in_ready stayed %b for 50 cycles", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    vec_count++;
    if (n >= 20) begin
      err_count++;
      $display("FAIL %s_out_valid_timeout: out_valid=%b after 20 cycles, want 1", tag, out_valid);
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vec_count++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      err_count++;
      $display("FAIL %s_release: out_valid=%b busy=%b, want 0 0", tag, out_valid, busy);
    end
  endtask

  task automatic check_result(input string tag, input logic [BW-1:0] z, input logic s);
    vec_count++;
    if (out_z !== z || out_sz !== s || out_zero !== 1'b0) begin
      err_count++;
      $display("FAIL %s_result: got z=%0d sz=%b zero=%b, want z=%0d sz=%b zero=0",
               tag, out_z, out_sz, out_zero, z, s);
    end
  endtask

  // ---- tests
  task automatic test_reset;
    rst_n = 1'b0;
    #2;
    vec_count++;
    if ({in_ready, out_valid, out_sz, out_zero, busy, add_sx} !== 6'b0 ||
        out_z !== '0 || add_x !== '0) begin
      err_count++;
      $display("FAIL reset_outputs: rdy=%b ov=%b z=%0d sz=%b zero=%b busy=%b ax=%0d asx=%b, want all 0",
               in_ready, out_valid, out_z, out_sz, out_zero, busy, add_x, add_sx);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vec_count++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      err_count++;
      $display("FAIL reset_idle: busy=%b in_ready=%b, want 0 0", busy, in_ready);
    end
  endtask

  task automatic test_single;
    do_start(8'd1);
    vec_count++;
    if (in_ready !== 1'b1 || busy !== 1'b1) begin
      err_count++;
      $display("FAIL single_first: in_ready=%b busy=%b, want 1 1", in_ready, busy);
    end
    send_op(18'd1024, 1'b0);
    vec_count++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      err_count++;
      $display("FAIL single_latency: out_valid=%b in_ready=%b one cycle after handshake, want 1 0",
               out_valid, in_ready);
    end
    check_result("single", 18'd1024, 1'b0);
    consume("single");
  endtask

  task automatic test_pair;
    do_start(8'd2);
    send_op(18'd1024, 1'b0);
    send_op(18'd1024, 1'b0);
    wait_out("pair");
    check_result("pair", 18'd1536, 1'b0);
    consume("pair");
  endtask

  task automatic test_zero_len;
    do_start(8'd0);
    vec_count++;
    if (out_valid !== 1'b1 || out_zero !== 1'b1 || out_z !== '0 || out_sz !== 1'b0) begin
      err_count++;
      $display("FAIL zero_result: ov=%b zero=%b z=%0d sz=%b, want 1 1 0 0",
               out_valid, out_zero, out_z, out_sz);
    end
    for (int i = 0; i < 3; i++) begin
      vec_count++;
      if (in_ready !== 1'b0) begin
        err_count++;
        $display("FAIL zero_in_ready: in_ready=%b in cycle %0d, want 0", in_ready, i);
      end
      @(negedge clk);
    end
    consume("zero");
    vec_count++;
    if (out_zero !== 1'b0) begin
      err_count++;
      $display("FAIL zero_clear: out_zero=%b after release, want 0", out_zero);
    end
  endtask

  // 4 + 4 + 8 + 16 = 32 -> log2 = 5.0 -> 2560
  task automatic test_gapped_backpressure;
    logic [BW-1:0] ops [4] = '{18'd1024, 18'd1024, 18'd1536, 18'd2048};
    do_start(8'd4);
    for (int i = 0; i < 4; i++) begin
      send_op(ops[i], 1'b0);
      if (i < 3) begin @(negedge clk); @(negedge clk); end
    end
    wait_out("gapped");
    for (int c = 0; c < 5; c++) begin
      vec_count++;
      if (out_valid !== 1'b1 || out_z !== 18'd2560 || out_sz !== 1'b0) begin
        err_count++;
        $display("FAIL gapped_hold: cycle %0d ov=%b z=%0d sz=%b, want 1 2560 0",
                 c, out_valid, out_z, out_sz);
      end
      @(negedge clk);
    end
    consume("gapped");
  endtask

  // 4 + 1 = 5 -> 1189 ; 8 - 1 = 7 -> 1437 ; -8 + 4 = -4 -> 1024 sign 1
  task automatic test_mixed_values;
    do_start(8'd2);
    send_op(18'd1024, 1'b0); send_op(18'd0, 1'b0);
    wait_out("mix_add"); check_result("mix_add", 18'd1189, 1'b0); consume("mix_add");
    do_start(8'd2);
    send_op(18'd1536, 1'b0); send_op(18'd0, 1'b1);
    wait_out("mix_sub"); check_result("mix_sub", 18'd1437, 1'b0); consume("mix_sub");
    do_start(8'd2);
    send_op(18'd1536, 1'b1); send_op(18'd1024, 1'b0);
    wait_out("mix_neg"); check_result("mix_neg", 18'd1024, 1'b1); consume("mix_neg");
  endtask

  task automatic test_reset_mid;
    do_start(8'd4);
    send_op(18'd1024, 1'b0);
    send_op(18'd1024, 1'b0);
    rst_n = 1'b0;
    #1;
    vec_count++;
    if ({in_ready, out_valid, out_sz, out_zero, busy, add_sx} !== 6'b0 ||
        out_z !== '0 || add_x !== '0) begin
      err_count++;
      $display("FAIL midreset_outputs: rdy=%b ov=%b z=%0d sz=%b zero=%b busy=%b ax=%0d, want all 0",
               in_ready, out_valid, out_z, out_sz, out_zero, busy, add_x);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(8'd2);
    send_op(18'd1024, 1'b0);
    send_op(18'd1024, 1'b0);
    wait_out("midreset");
    check_result("midreset", 18'd1536, 1'b0);
    consume("midreset");
  endtask

  // 4 + 4 + 8 = 16 -> 2048, in_valid held high throughout
  task automatic test_back_to_back;
    logic [BW-1:0] ops [3] = '{18'd1024, 18'd1024, 18'd1536};
    logic [5:0] rdy_pat, ov_pat, rdy_exp, ov_exp;
    int k = 0;
`ifdef LNS_ACC_REG_EN
    rdy_exp = 6'b110100; ov_exp = 6'b000001;
`else
    rdy_exp = 6'b111000; ov_exp = 6'b000111;
`endif
    do_start(8'd3);
    for (int c = 0; c < 6; c++) begin
      rdy_pat[5-c] = in_ready;
      ov_pat[5-c]  = out_valid;
      in_valid = (k < 3);
      in_x     = ops[(k < 3) ? k : 2];
      in_sx    = 1'b0;
      if (in_valid && in_ready) k++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    vec_count++;
    if (rdy_pat !== rdy_exp) begin
      err_count++;
      $display("FAIL b2b_in_ready: pattern %b, want %b", rdy_pat, rdy_exp);
    end
    vec_count++;
    if (ov_pat !== ov_exp) begin
      err_count++;
      $display("FAIL b2b_out_valid: pattern %b, want %b", ov_pat, ov_exp);
    end
    check_result("b2b", 18'd2048, 1'b0);
    consume("b2b");
  endtask

  initial begin
    start = 1'b0; len_v = '0; in_valid = 1'b0; in_x = '0; in_sx = 1'b0; out_ready = 1'b0;
    test_reset;
    test_single;
    test_pair;
    test_zero_len;
    test_gapped_backpressure;
    test_mixed_values;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
